// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants, legality check and arbiter state encoding shared
// by the ALU, the ALU share arbiter and the control unit.
package alu_pkg;

    localparam int unsigned ALU_OP_W = 6;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 6'b000000;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 6'b000001;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 6'b000010;
    localparam logic [ALU_OP_W-1:0] ALU_NOR = 6'b000011;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 6'b000100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    // The downstream ALU latches on unlisted codes, so only these may reach it.
    function automatic logic is_legal_op(input logic [ALU_OP_W-1:0] op);
        case (op)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_NOR, ALU_OR: return 1'b1;
            default:                                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: request/response channels of the shared-ALU arbiter
// plus the operand/opcode/result wires to the ALU beside it.
//   req_*      : per-requester request, fields packed i*W +: W
//   resp_*     : per-requester valid/ready, shared result and error flag
//   alu_*      : operands/opcode to the ALU, result back from it
// master = requesters + ALU side, slave = arbiter.
interface alu_share_arbiter_if #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned OP_W    = 6
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ*OP_W-1:0]   req_op;
    logic [NUM_REQ-1:0]        resp_valid;
    logic [NUM_REQ-1:0]        resp_ready;
    logic [DATA_W-1:0]         resp_result;
    logic                      resp_err;
    logic [DATA_W-1:0]         alu_a;
    logic [DATA_W-1:0]         alu_b;
    logic [OP_W-1:0]           alu_op;
    logic [DATA_W-1:0]         alu_result;

    modport master (
        output req_valid, req_a, req_b, req_op, resp_ready, alu_result,
        input  req_ready, resp_valid, resp_result, resp_err, alu_a, alu_b, alu_op
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, resp_ready, alu_result,
        output req_ready, resp_valid, resp_result, resp_err, alu_a, alu_b, alu_op
    );
endinterface

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick. Grants the first set req_i bit
// searching upward from ptr_i, wrapping modulo N.
//   req_i   : request vector
//   ptr_i   : highest-priority index
//   grant_o : one-hot grant, zero when no request
module rr_arbiter #(
    parameter  int unsigned N     = 2,
    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o
);

    logic        found;
    int unsigned idx;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr_i) + k) % N;
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one ALU between NUM_REQ requesters. Round-robin
// accept in IDLE, one EXEC cycle while the ALU settles, then RESP holds the
// result for the originating requester until it is taken.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : request/response channels and ALU operand/result wires
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned OP_W    = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_share_arbiter_if.slave bus
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e          state_q, state_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]    id_q, id_d;
    logic [DATA_W-1:0]   alu_a_q, alu_a_d;
    logic [DATA_W-1:0]   alu_b_q, alu_b_d;
    logic [OP_W-1:0]     alu_op_q, alu_op_d;
    logic [NUM_REQ-1:0]  resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]   resp_result_q, resp_result_d;
    logic                resp_err_q, resp_err_d;

    logic [NUM_REQ-1:0]  grant;
    logic [NUM_REQ-1:0]  req_ready;
    logic [PTR_W-1:0]    gnt_id;
    logic [DATA_W-1:0]   sel_a;
    logic [DATA_W-1:0]   sel_b;
    logic [OP_W-1:0]     sel_op;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req_i   (bus.req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant)
    );

    always_comb begin
        gnt_id = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) gnt_id = PTR_W'(i);
        end
    end

    assign sel_a  = bus.req_a[gnt_id*DATA_W +: DATA_W];
    assign sel_b  = bus.req_b[gnt_id*DATA_W +: DATA_W];
    assign sel_op = bus.req_op[gnt_id*OP_W +: OP_W];

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        id_d          = id_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_op_d      = alu_op_q;
        resp_valid_d  = resp_valid_q;
        resp_result_d = resp_result_q;
        resp_err_d    = resp_err_q;
        req_ready     = '0;

        case (state_q)
            IDLE: begin
                // Gated by rst_n so nothing is offered while reset is held.
                if (rst_n) req_ready = grant;
                if (|req_ready) begin
                    id_d     = gnt_id;
                    rr_ptr_d = (gnt_id == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
                    if (is_legal_op(ALU_OP_W'(sel_op))) begin
                        alu_a_d  = sel_a;
                        alu_b_d  = sel_b;
                        alu_op_d = sel_op;
                        state_d  = EXEC;
                    end else begin
                        resp_result_d = '0;
                        resp_err_d    = 1'b1;
                        resp_valid_d  = grant;
                        state_d       = RESP;
                    end
                end
            end
            EXEC: begin
                resp_result_d        = bus.alu_result;
                resp_err_d           = 1'b0;
                resp_valid_d         = '0;
                resp_valid_d[id_q]   = 1'b1;
                state_d              = RESP;
            end
            RESP: begin
                if (bus.resp_ready[id_q]) begin
                    resp_valid_d = '0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            id_q          <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_op_q      <= '0;
            resp_valid_q  <= '0;
            resp_result_q <= '0;
            resp_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            id_q          <= id_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_op_q      <= alu_op_d;
            resp_valid_q  <= resp_valid_d;
            resp_result_q <= resp_result_d;
            resp_err_q    <= resp_err_d;
        end
    end

    assign bus.req_ready   = req_ready;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_result = resp_result_q;
    assign bus.resp_err    = resp_err_q;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_op      = alu_op_q;

endmodule
